// File: rtl/noteid2freq_mc.sv
// Multi-channel note-ID to frequency converter: scans the channels round-robin and
// recomputes a channel's frequency by iterated fixed-point semitone multiplication.
module noteid2freq_mc #(
  parameter int CHANNELS = 4,
  parameter int NOTE_W   = 8,
  parameter int FREQ_W   = 16,
  parameter int FRAC     = 10,
  parameter int C0_FX    = 8372,
  parameter int RATIO_FX = 1085,
  parameter int TRANS_W  = 6,
  parameter int MAX_NOTE = 127
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*NOTE_W-1:0]   noteid,
  input  logic [TRANS_W-1:0]           transpose,
  output logic [CHANNELS*FREQ_W-1:0]   freq,
  output logic [CHANNELS-1:0]          freq_valid,
  output logic                         busy
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW    = ((NOTE_W > TRANS_W) ? NOTE_W : TRANS_W) + 2;
  localparam int AW    = FREQ_W + FRAC + 1;
  localparam int RW    = $clog2(RATIO_FX + 1);
  localparam int PRW   = AW + RW;
  localparam logic [AW-1:0] SAT_ACC = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [SW-1:0] clamp_note(input logic signed [SW-1:0] s);
    logic [SW-1:0] r;
    if (s[SW-1] == 1'b1 || s == '0) begin
      r = SW'(1);
    end else if (s > SW'(MAX_NOTE)) begin
      r = SW'(MAX_NOTE);
    end else begin
      r = s;
    end
    return r;
  endfunction

  // One semitone step; the accumulator parks at SAT_ACC instead of wrapping.
  function automatic logic [AW-1:0] mul_step(input logic [AW-1:0] a);
    logic [PRW-1:0] p;
    logic [AW-1:0]  r;
    p = (PRW'(a) * PRW'(RATIO_FX)) >> FRAC;
    if (p > PRW'(SAT_ACC)) begin
      r = SAT_ACC;
    end else begin
      r = p[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic [FREQ_W-1:0] sat_freq(input logic [AW-1:0] a);
    logic [AW-1:0]     q;
    logic [FREQ_W-1:0] r;
    q = a >> FRAC;
    if (|q[AW-1:FREQ_W]) begin
      r = {FREQ_W{1'b1}};
    end else begin
      r = q[FREQ_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(CHANNELS - 1)) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  state_t             state_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [NOTE_W-1:0]  last_note_r [CHANNELS];
  logic [CHANNELS-1:0] stale_r;
  logic [TRANS_W-1:0] last_trans_r;
  logic [AW-1:0]      acc_r;
  logic [SW-1:0]      cnt_r;
  logic [SW-1:0]      eff_r;

  logic [NOTE_W-1:0]  cur_note_s;
  logic               dirty_s;
  logic               trans_chg_s;
  logic signed [SW-1:0] sum_s;
  logic [SW-1:0]      eff_s;

  // Decode the channel under the scan pointer and its clamped effective note.
  always_comb begin
    cur_note_s  = noteid[int'(ptr_r)*NOTE_W +: NOTE_W];
    dirty_s     = (cur_note_s != last_note_r[ptr_r]) || stale_r[ptr_r];
    trans_chg_s = (transpose != last_trans_r);
    sum_s       = $signed(SW'(cur_note_s)) +
                  $signed({{(SW-TRANS_W){transpose[TRANS_W-1]}}, transpose});
    eff_s       = clamp_note(sum_s);
  end

  // Scan / multiply / post sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SCAN;
      ptr_r        <= '0;
      stale_r      <= '0;
      last_trans_r <= '0;
      acc_r        <= '0;
      cnt_r        <= '0;
      eff_r        <= '0;
      freq         <= '0;
      freq_valid   <= '0;
      busy         <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        last_note_r[k] <= '0;
      end
    end else begin
      freq_valid <= '0;
      // A transpose change invalidates every channel, including the one in flight.
      if (trans_chg_s) begin
        stale_r      <= '1;
        last_trans_r <= transpose;
      end
      case (state_r)
        SCAN: begin
          if (!trans_chg_s) begin
            if (dirty_s) begin
              last_note_r[ptr_r] <= cur_note_s;
              stale_r[ptr_r]     <= 1'b0;
              if (cur_note_s == '0) begin
                freq[int'(ptr_r)*FREQ_W +: FREQ_W] <= '0;
                freq_valid[ptr_r] <= 1'b1;
                ptr_r             <= next_ptr(ptr_r);
              end else begin
                acc_r   <= AW'(C0_FX);
                cnt_r   <= SW'(1);
                eff_r   <= eff_s;
                state_r <= MUL;
                busy    <= 1'b1;
              end
            end else begin
              ptr_r <= next_ptr(ptr_r);
            end
          end
        end
        MUL: begin
          acc_r <= mul_step(acc_r);
          cnt_r <= cnt_r + SW'(1);
          if (cnt_r >= eff_r) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          freq[int'(ptr_r)*FREQ_W +: FREQ_W] <= sat_freq(acc_r);
          freq_valid[ptr_r] <= 1'b1;
          ptr_r             <= next_ptr(ptr_r);
          state_r           <= SCAN;
          busy              <= 1'b0;
        end
        default: begin
          state_r <= SCAN;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noteid2freq_mc.sv
// Directed bench for noteid2freq_mc: a cycle-level reference of the scan schedule
// with an arithmetic frequency model, checked every cycle, plus literal spot checks.
module tb_noteid2freq_mc;

  localparam int CH  = 4;
  localparam int NW  = 8;
  localparam int FW  = 16;
  localparam int TW  = 6;
  localparam int CH8 = 2;
  localparam int FW8 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [CH*NW-1:0]   noteid    = '0;
  logic [TW-1:0]      transpose = '0;
  logic [CH*FW-1:0]   freq;
  logic [CH-1:0]      freq_valid;
  logic               busy;

  logic [CH8*NW-1:0]  noteid8    = '0;
  logic [TW-1:0]      transpose8 = '0;
  logic [CH8*FW8-1:0] freq8;
  logic [CH8-1:0]     freq_valid8;
  logic               busy8;

  noteid2freq_mc #(.CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .noteid(noteid), .transpose(transpose),
    .freq(freq), .freq_valid(freq_valid), .busy(busy)
  );

  noteid2freq_mc #(.CHANNELS(CH8), .FREQ_W(FW8)) dut8 (
    .clk(clk), .rst_n(rst_n), .noteid(noteid8), .transpose(transpose8),
    .freq(freq8), .freq_valid(freq_valid8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff_of(input int note, input int tr);
    int e;
    e = note + tr;
    if (e < 1) e = 1;
    if (e > 127) e = 127;
    return e;
  endfunction

  // Plain-arithmetic frequency: repeated truncating multiply from C0, clipped.
  function automatic longint freq_of(input int note, input int tr, input int fw);
    longint acc, sat, f, fmax;
    if (note == 0) return 0;
    acc  = 8372;
    sat  = longint'(1) << (fw + 10);
    fmax = (longint'(1) << fw) - 1;
    for (int i = 0; i < eff_of(note, tr); i++) begin
      acc = (acc * 1085) >>> 10;
      if (acc > sat) acc = sat;
    end
    f = acc >>> 10;
    if (f > fmax) f = fmax;
    return f;
  endfunction

  // Reference schedule: service points and the cycle each result must appear.
  int         m_ptr, m_ltrans, m_wait, m_pch;
  int         m_last [CH];
  bit         m_stale [CH];
  longint     m_pval;
  logic [CH*FW-1:0] e_freq;
  logic [CH-1:0]    e_valid;
  logic             e_busy;

  function automatic int note_of(input int k);
    return int'(noteid[k*NW +: NW]);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_ltrans = 0; m_wait = 0; m_pch = 0; m_pval = 0;
    for (int k = 0; k < CH; k++) begin
      m_last[k] = 0;
      m_stale[k] = 1'b0;
    end
    e_freq = '0; e_valid = '0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    int tr, n;
    tr = int'($signed(transpose));
    e_valid = '0;
    if (m_wait > 0) begin
      if (tr != m_ltrans) begin
        for (int k = 0; k < CH; k++) m_stale[k] = 1'b1;
        m_ltrans = tr;
      end
      m_wait--;
      if (m_wait == 0) begin
        e_freq[m_pch*FW +: FW] = FW'(m_pval);
        e_valid[m_pch] = 1'b1;
        m_ptr = (m_ptr + 1) % CH;
      end
    end else if (tr != m_ltrans) begin
      for (int k = 0; k < CH; k++) m_stale[k] = 1'b1;
      m_ltrans = tr;
    end else begin
      n = note_of(m_ptr);
      if (n != m_last[m_ptr] || m_stale[m_ptr]) begin
        m_last[m_ptr]  = n;
        m_stale[m_ptr] = 1'b0;
        if (n == 0) begin
          e_freq[m_ptr*FW +: FW] = '0;
          e_valid[m_ptr] = 1'b1;
          m_ptr = (m_ptr + 1) % CH;
        end else begin
          m_pch  = m_ptr;
          m_pval = freq_of(n, tr, FW);
          m_wait = eff_of(n, tr) + 1;
        end
      end else begin
        m_ptr = (m_ptr + 1) % CH;
      end
    end
    e_busy = (m_wait > 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the reference, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_freq_valid", 64'(freq_valid), 64'(e_valid));
        chk("cyc_freq", 64'(freq), 64'(e_freq));
        chk("cyc_busy", 64'(busy), 64'(e_busy));
      end
    end
  end

  task automatic set_note(input int k, input int v);
    noteid[k*NW +: NW] = NW'(v);
  endtask

  task automatic wait_pulse(input int ch, input int limit, output longint val);
    bit ok;
    ok = 1'b0;
    val = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (freq_valid[ch]) begin
        val = longint'(freq[ch*FW +: FW]);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_pulse ch%0d: no freq_valid within %0d cycles", ch, limit);
    end
  endtask

  task automatic wait_pulse8(input int ch, input int limit, output longint val);
    bit ok;
    ok = 1'b0;
    val = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (freq_valid8[ch]) begin
        val = longint'(freq8[ch*FW8 +: FW8]);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_pulse8 ch%0d: no freq_valid within %0d cycles", ch, limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    int quiet;
    bit ok;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy && freq_valid == '0) quiet++;
      else quiet = 0;
      if (quiet >= 2*CH + 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: still active after %0d cycles", limit);
    end
  endtask

  task automatic wait_busy(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_busy: busy never rose within %0d cycles", limit);
    end
  endtask

  initial begin
    longint v;
    int     seq [$];
    longint vals [CH];
    int     c;

    // Model pins from hand arithmetic: 8372*1085>>10 = 8870 -> 8 Hz.
    chk("model_note1", 64'(freq_of(1, 0, FW)), 64'd8);
    chk("model_note12", 64'(freq_of(12, 0, FW)), 64'd16);
    chk("model_sat8", 64'(freq_of(127, 0, FW8)), 64'd255);
    chk("model_clamp_low", 64'(freq_of(5, -32, FW)), 64'd8);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_freq", 64'(freq), 64'd0);
    chk("idle_valid", 64'(freq_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    set_note(0, 1);
    wait_pulse(0, 200, v);
    chk("ch0_note1", 64'(v), 64'd8);
    wait_idle(3000);

    set_note(0, 12);
    wait_pulse(0, 200, v);
    chk("ch0_note12", 64'(v), 64'd16);
    wait_idle(3000);

    set_note(2, 69);
    wait_pulse(2, 300, v);
    chk("ch2_a4_model", 64'(v), 64'(freq_of(69, 0, FW)));
    chk("ch2_a4_range", 64'((v >= 435) && (v <= 450)), 64'd1);
    wait_idle(3000);

    // All four channels change together: four separate pulses in scan order.
    set_note(0, 10); set_note(1, 20); set_note(2, 30); set_note(3, 40);
    for (int i = 0; i < 3000 && seq.size() < CH; i++) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        if (freq_valid[k]) begin
          seq.push_back(k);
          vals[k] = longint'(freq[k*FW +: FW]);
        end
      end
    end
    chk("multi_count", 64'(seq.size()), 64'(CH));
    if (seq.size() == CH) begin
      for (int i = 1; i < CH; i++) begin
        chk("multi_order", 64'(seq[i]), 64'((seq[0] + i) % CH));
      end
      for (int k = 0; k < CH; k++) begin
        chk("multi_value", 64'(vals[k]), 64'(freq_of(10 + 10*k, 0, FW)));
      end
    end
    wait_idle(3000);

    set_note(1, 60);
    wait_pulse(1, 300, v);
    chk("ch1_note60", 64'(v), 64'(freq_of(60, 0, FW)));
    wait_idle(3000);
    transpose = TW'(12);
    wait_pulse(1, 1500, v);
    chk("ch1_trans12", 64'(v), 64'(freq_of(72, 0, FW)));
    wait_idle(3000);

    transpose = TW'(-32);
    set_note(3, 5);
    wait_pulse(3, 1500, v);
    chk("ch3_clamp_low", 64'(v), 64'd8);
    wait_idle(3000);

    transpose = '0;
    wait_idle(3000);
    // Note change while the same channel is mid-computation.
    set_note(0, 100);
    wait_busy(50);
    repeat (3) @(negedge clk);
    set_note(0, 50);
    wait_pulse(0, 300, v);
    chk("ch0_inflight_old", 64'(v), 64'(freq_of(100, 0, FW)));
    wait_pulse(0, 600, v);
    chk("ch0_inflight_new", 64'(v), 64'(freq_of(50, 0, FW)));
    wait_idle(3000);
    set_note(0, 0);
    wait_pulse(0, 50, v);
    chk("ch0_note_off", 64'(v), 64'd0);
    wait_idle(3000);

    // Asynchronous reset in the middle of a long multiply.
    set_note(1, 127);
    wait_busy(50);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_freq", 64'(freq), 64'd0);
    chk("rst_mid_valid", 64'(freq_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 64'(freq_valid), 64'd0);
    rst_n = 1'b1;
    wait_idle(3000);
    chk("ch1_after_rst", 64'(freq[1*FW +: FW]), 64'(freq_of(127, 0, FW)));
    chk("ch2_after_rst", 64'(freq[2*FW +: FW]), 64'(freq_of(30, 0, FW)));

    // Narrow output instance: saturation at 2^8-1.
    noteid8[0*NW +: NW] = NW'(127);
    wait_pulse8(0, 600, v);
    chk("w8_note127_sat", 64'(v), 64'd255);
    noteid8[1*NW +: NW] = NW'(1);
    wait_pulse8(1, 600, v);
    chk("w8_note1", 64'(v), 64'd8);
    noteid8[0*NW +: NW] = NW'(40);
    wait_pulse8(0, 600, v);
    chk("w8_note40", 64'(v), 64'(freq_of(40, 0, FW8)));
    noteid8[0*NW +: NW] = NW'(69);
    wait_pulse8(0, 600, v);
    chk("w8_note69_sat", 64'(v), 64'd255);

    c = checks;
    $display("Result: errors=%0d of %0d checks", errors, c);
    $finish;
  end

endmodule
